// File: rtl/ysyx_24090003_issue.sv
// rtl/ysyx_24090003_issue.sv - instruction queue with optional RAW scoreboard between fetch and decode
//
// Purpose: buffers fetched instructions in a DEPTH-entry FIFO and issues the
// head to decode. With YSYX_24090003_ISSUE_SCOREBOARD_EN defined, a busy-register
// scoreboard holds the head back while any source it reads awaits writeback.
// Without the macro the block is a plain FIFO and wb_valid/wb_rd are ignored.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   ifu_valid/ifu_inst/ifu_pc  fetch side offer; ifu_ready back-pressure
//   id_valid/id_inst/id_pc     head instruction to decode; id_ready accept
//   wb_valid/wb_rd             register write retired by writeback
//   flush                      discard everything queued
//   stall_raw                  head is held back by a RAW hazard
module ysyx_24090003_issue #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ifu_valid,
    input  logic [31:0] ifu_inst,
    input  logic [31:0] ifu_pc,
    output logic        ifu_ready,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    input  logic        id_ready,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic        flush,
    output logic        stall_raw
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      inst_q [DEPTH];
    logic [31:0]      pc_q   [DEPTH];

    logic not_empty;
    logic hazard;
    logic do_enq;
    logic do_deq;

    assign not_empty = (count_q != '0);

    // Head is read straight from storage, so a new entry appears one cycle after its enqueue.
    assign id_inst   = inst_q[rptr_q];
    assign id_pc     = pc_q[rptr_q];

    // Flush blocks both handshakes in the cycle it is asserted.
    assign ifu_ready = (count_q != FULL_CNT) && !flush;
    assign id_valid  = not_empty && !hazard && !flush;
    assign stall_raw = not_empty && hazard;

    assign do_enq = ifu_valid && ifu_ready;
    assign do_deq = id_valid && id_ready;

    always_comb begin
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        if (flush) begin
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
        end else begin
            if (do_enq) wptr_d = wptr_q + PTR_W'(1);
            if (do_deq) rptr_d = rptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(do_enq) - CNT_W'(do_deq);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                inst_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else if (do_enq) begin
            inst_q[wptr_q] <= ifu_inst;
            pc_q[wptr_q]   <= ifu_pc;
        end
    end

`ifdef YSYX_24090003_ISSUE_SCOREBOARD_EN
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic [31:0] busy_q, busy_d;
    logic [6:0]  opcode;
    logic [4:0]  rs1, rs2, rd;
    logic        use_rs1, use_rs2, writes_rd;

    assign opcode = id_inst[6:0];
    assign rd     = id_inst[11:7];
    assign rs1    = id_inst[19:15];
    assign rs2    = id_inst[24:20];

    assign use_rs1   = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
    assign use_rs2   = (opcode == OP_REG) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
    assign writes_rd = (rd != 5'd0) && (opcode != OP_STORE) && (opcode != OP_BRANCH);

    // busy[0] is always 0, so reads of x0 never stall.
    assign hazard = (use_rs1 && busy_q[rs1]) || (use_rs2 && busy_q[rs2]);

    // Clear before set: an issuing write to the register being retired keeps it busy.
    always_comb begin
        busy_d = busy_q;
        if (wb_valid) busy_d[wb_rd] = 1'b0;
        if (do_deq && writes_rd) busy_d[rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end
`else
    logic unused_wb;

    assign hazard    = 1'b0;
    assign unused_wb = ^{wb_valid, wb_rd};
`endif

endmodule

// File: tb/tb_ysyx_24090003_issue.sv
// tb/tb_ysyx_24090003_issue.sv - self-checking bench for ysyx_24090003_issue
module tb_ysyx_24090003_issue;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ifu_valid;
    logic [31:0] ifu_inst;
    logic [31:0] ifu_pc;
    logic        ifu_ready;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        id_ready;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush;
    logic        stall_raw;

    always #5 clk = ~clk;

    ysyx_24090003_issue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ifu_valid (ifu_valid),
        .ifu_inst  (ifu_inst),
        .ifu_pc    (ifu_pc),
        .ifu_ready (ifu_ready),
        .id_valid  (id_valid),
        .id_inst   (id_inst),
        .id_pc     (id_pc),
        .id_ready  (id_ready),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .flush     (flush),
        .stall_raw (stall_raw)
    );

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    ent_t q[$];
    bit   busy[32];
    int   errors = 0;
    int   checks = 0;

    logic        s_ready, s_valid, s_stall;
    logic [31:0] s_pc;

    localparam logic [31:0] NOP      = 32'h00000013; // addi x0,x0,0
    localparam logic [31:0] ADDI5    = 32'h00100293; // addi x5,x0,1
    localparam logic [31:0] ADD6_55  = 32'h00528333; // add  x6,x5,x5
    localparam logic [31:0] SW5_2    = 32'h00512023; // sw   x5,0(x2)
    localparam logic [31:0] ADDI7    = 32'h00100393; // addi x7,x0,1
    localparam logic [31:0] ADD8_70  = 32'h00038433; // add  x8,x7,x0

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference rules: which sources an instruction reads and whether it writes rd.
    function automatic bit model_hazard(input logic [31:0] inst);
`ifdef YSYX_24090003_ISSUE_SCOREBOARD_EN
        logic [6:0] op;
        bit r1, r2;
        op = inst[6:0];
        r1 = !(op inside {7'b0110111, 7'b0010111, 7'b1101111});
        r2 = op inside {7'b0110011, 7'b0100011, 7'b1100011};
        return (r1 && busy[inst[19:15]]) || (r2 && busy[inst[24:20]]);
`else
        return inst[0] & 1'b0;
`endif
    endfunction

    function automatic bit model_writes(input logic [31:0] inst);
        return (inst[11:7] != 5'd0) && !(inst[6:0] inside {7'b0100011, 7'b1100011});
    endfunction

    task automatic step(input logic iv, input logic [31:0] inst, input logic [31:0] pc,
                        input logic idr, input logic wbv, input logic [4:0] wbrd, input logic fl);
        bit e_ready, e_valid, haz;
        ent_t e;
        ifu_valid = iv;
        ifu_inst  = inst;
        ifu_pc    = pc;
        id_ready  = idr;
        wb_valid  = wbv;
        wb_rd     = wbrd;
        flush     = fl;
        @(negedge clk);
        s_ready = ifu_ready;
        s_valid = id_valid;
        s_stall = stall_raw;
        s_pc    = id_pc;
        haz     = (q.size() != 0) && model_hazard(q[0].inst);
        e_ready = (q.size() < DEPTH) && !fl;
        e_valid = (q.size() != 0) && !haz && !fl;
        chk("ifu_ready", {31'd0, ifu_ready}, {31'd0, e_ready});
        chk("id_valid",  {31'd0, id_valid},  {31'd0, e_valid});
        chk("stall_raw", {31'd0, stall_raw}, {31'd0, haz});
        if (q.size() != 0) begin
            chk("id_inst", id_inst, q[0].inst);
            chk("id_pc",   id_pc,   q[0].pc);
        end
        if (wbv) busy[wbrd] = 1'b0;
        if (fl) begin
            q.delete();
        end else begin
            if (e_valid && idr) begin
                if (model_writes(q[0].inst)) busy[q[0].inst[11:7]] = 1'b1;
                void'(q.pop_front());
            end
            if (e_ready && iv) begin
                e.inst = inst;
                e.pc   = pc;
                q.push_back(e);
            end
        end
        busy[0] = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic idr);
        step(1'b0, 32'h0, 32'h0, idr, 1'b0, 5'd0, 1'b0);
    endtask

    function automatic logic [31:0] rand_inst();
        logic [6:0] ops [8];
        logic [31:0] w;
        ops[0] = 7'b0010011; ops[1] = 7'b0110011; ops[2] = 7'b0100011; ops[3] = 7'b1100011;
        ops[4] = 7'b0110111; ops[5] = 7'b0010111; ops[6] = 7'b1101111; ops[7] = 7'b0000011;
        w = $urandom;
        w[6:0]   = ops[$urandom_range(0, 7)];
        w[11:7]  = 5'($urandom_range(0, 3));
        w[19:15] = 5'($urandom_range(0, 3));
        w[24:20] = 5'($urandom_range(0, 3));
        return w;
    endfunction

    initial begin
        rst_n = 1'b0; ifu_valid = 0; ifu_inst = 0; ifu_pc = 0;
        id_ready = 0; wb_valid = 0; wb_rd = 0; flush = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ifu_ready", {31'd0, ifu_ready}, 32'd1);
        chk("rst_id_valid",  {31'd0, id_valid},  32'd0);
        chk("rst_id_inst",   id_inst, 32'd0);
        chk("rst_id_pc",     id_pc,   32'd0);
        chk("rst_stall",     {31'd0, stall_raw}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fill and drain
        step(1'b1, NOP, 32'h100, 1'b0, 1'b0, 5'd0, 1'b0);
        step(1'b1, NOP, 32'h104, 1'b0, 1'b0, 5'd0, 1'b0);
        chk("fill_valid", {31'd0, s_valid}, 32'd1);
        step(1'b1, NOP, 32'h108, 1'b0, 1'b0, 5'd0, 1'b0);
        chk("fill_full_ready", {31'd0, s_ready}, 32'd0);
        idle(1'b1);
        chk("drain_pc0", s_pc, 32'h100);
        idle(1'b1);
        chk("drain_pc1", s_pc, 32'h104);
        idle(1'b1);
        chk("drain_empty", {31'd0, s_valid}, 32'd0);

`ifdef YSYX_24090003_ISSUE_SCOREBOARD_EN
        // RAW stall until x5 retires
        step(1'b1, ADDI5,   32'h200, 1'b1, 1'b0, 5'd0, 1'b0);
        step(1'b1, ADD6_55, 32'h204, 1'b1, 1'b0, 5'd0, 1'b0);
        idle(1'b1);
        chk("raw_stall", {31'd0, s_stall}, 32'd1);
        idle(1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 5'd5, 1'b0);
        chk("raw_stall_wb_cycle", {31'd0, s_valid}, 32'd0);
        idle(1'b1);
        chk("raw_issue_after_wb", s_pc, 32'h204);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 5'd6, 1'b0);

        // x0 destination and store: no stall
        step(1'b1, NOP,   32'h300, 1'b0, 1'b0, 5'd0, 1'b0);
        step(1'b1, SW5_2, 32'h304, 1'b0, 1'b0, 5'd0, 1'b0);
        idle(1'b1);
        idle(1'b1);
        chk("noreg_sw_issue", {31'd0, s_valid}, 32'd1);
        chk("noreg_sw_stall", {31'd0, s_stall}, 32'd0);
        idle(1'b1);

        // Retire and re-issue x7 in the same cycle
        step(1'b1, ADDI7,   32'h400, 1'b1, 1'b0, 5'd0, 1'b0);
        step(1'b1, ADDI7,   32'h404, 1'b1, 1'b0, 5'd0, 1'b0);
        step(1'b1, ADD8_70, 32'h408, 1'b1, 1'b1, 5'd7, 1'b0);
        idle(1'b1);
        chk("collide_stall", {31'd0, s_stall}, 32'd1);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 5'd7, 1'b0);
        idle(1'b1);
        chk("collide_issue", s_pc, 32'h408);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 5'd8, 1'b0);
`endif

        // Flush with two queued and a pending offer
        step(1'b1, NOP, 32'h500, 1'b0, 1'b0, 5'd0, 1'b0);
        step(1'b1, NOP, 32'h504, 1'b0, 1'b0, 5'd0, 1'b0);
        step(1'b1, NOP, 32'h508, 1'b1, 1'b0, 5'd0, 1'b1);
        chk("flush_ready", {31'd0, s_ready}, 32'd0);
        idle(1'b1);
        chk("flush_empty", {31'd0, s_valid}, 32'd0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 9) < 7), rand_inst(), $urandom,
                 1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 3)), 1'($urandom_range(0, 29) == 0));
        end

        // Reset mid-transfer
        step(1'b1, NOP, 32'h600, 1'b0, 1'b0, 5'd0, 1'b0);
        ifu_valid = 1'b1; ifu_inst = NOP; ifu_pc = 32'h604; id_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_ifu_ready", {31'd0, ifu_ready}, 32'd1);
        chk("midrst_id_valid",  {31'd0, id_valid},  32'd0);
        chk("midrst_id_inst",   id_inst, 32'd0);
        chk("midrst_id_pc",     id_pc,   32'd0);
        chk("midrst_stall",     {31'd0, stall_raw}, 32'd0);
        q.delete();
        foreach (busy[i]) busy[i] = 1'b0;
        ifu_valid = 0; id_ready = 0; wb_valid = 0; flush = 0;
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, NOP, 32'h700, 1'b0, 1'b0, 5'd0, 1'b0);
        idle(1'b1);
        chk("post_rst_pc", s_pc, 32'h700);
        idle(1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ysyx_24090003_issue.md
YSYX_24090003_ISSUE -- requirements
Module: ysyx_24090003_ISSUE

Interface
REQ-001 SHALL have parameter DEPTH, default 2, instruction queue entries (power of two, 2..8).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port ifu_valid  input  1  fetch offers an instruction.
REQ-005 SHALL have port ifu_inst  input  32  fetched instruction word.
REQ-006 SHALL have port ifu_pc  input  32  PC of ifu_inst.
REQ-007 SHALL have port ifu_ready  output  1  queue can accept.
REQ-008 SHALL have port id_valid  output  1  head instruction issuable to decode.
REQ-009 SHALL have port id_inst  output  32  head instruction word, fed to the decoder inst input.
REQ-010 SHALL have port id_pc  output  32  head PC.
REQ-011 SHALL have port id_ready  input  1  decode/execute accepts.
REQ-012 SHALL have port wb_valid  input  1  writeback retires a register write.
REQ-013 SHALL have port wb_rd  input  5  register written back.
REQ-014 SHALL have port flush  input  1  discard all queued instructions.
REQ-015 SHALL have port stall_raw  output  1  head held back by a RAW hazard.

Function
REQ-016 SHALL hold instructions in a DEPTH-entry FIFO with read/write pointers wrapping modulo DEPTH and a count of width log2(DEPTH)+1.
REQ-017 SHALL drive ifu_ready = (count != DEPTH); enqueue on ifu_valid && ifu_ready; no enqueue while full even if dequeuing that cycle.
REQ-018 SHALL present the head entry on id_inst/id_pc combinationally from storage; minimum latency from enqueue to id_valid is 1 cycle (no input-to-output bypass).
REQ-019 SHALL dequeue on id_valid && id_ready; simultaneous enqueue and dequeue leaves count unchanged.
REQ-020 SHALL drive id_valid = (count != 0) && !hazard; when empty, id_valid=0 and stall_raw=0.
REQ-021 SHALL keep a 32-bit busy scoreboard; bit 0 is hard-wired 0.
REQ-022 SHALL flag rs1 use (inst[19:15]) for all opcodes except LUI 0110111, AUIPC 0010111, JAL 1101111.
REQ-023 SHALL flag rs2 use (inst[24:20]) only for opcodes 0110011, 0100011, 1100011.
REQ-024 SHALL assert hazard when a used source register has its busy bit set; stall_raw = (count != 0) && hazard.
REQ-025 SHALL set busy[rd] (rd = inst[11:7]) on issue when rd != 0 and opcode is not 0100011 (store) or 1100011 (branch).
REQ-026 SHALL clear busy[wb_rd] on wb_valid; a same-cycle set and clear of the same register leaves the bit set.
REQ-027 SHALL, on flush, zero count and both pointers in the next cycle, block enqueue and issue that cycle (ifu_ready and id_valid forced 0), and leave the scoreboard unchanged.

Reset
REQ-028 SHALL, on rst_n low, asynchronously clear count, pointers, FIFO storage and scoreboard, giving ifu_ready=1, id_valid=0, id_inst=0, id_pc=0, stall_raw=0.
REQ-029 SHALL discard any in-flight handshake when reset asserts mid-operation; first enqueue occurs on the first rising edge with rst_n high.

Configuration
REQ-030 SHALL, with YSYX_24090003_ISSUE_SCOREBOARD_EN defined, implement REQ-021..REQ-026 as specified.
REQ-031 SHALL, without YSYX_24090003_ISSUE_SCOREBOARD_EN, omit the scoreboard, force hazard=0 and stall_raw=0, ignore wb_valid/wb_rd, and behave as a pure FIFO.

Verification
REQ-032 SHALL cover fill/drain: DEPTH=2, id_ready=0, push 3 instructions -> ifu_ready=0 after 2 accepts; id_ready=1 -> PCs emerge in order, one per cycle.
REQ-033 SHALL cover RAW stall: issue addi x5,x0,1 then add x6,x5,x5 -> stall_raw=1, id_valid=0 until wb_valid with wb_rd=5, then issue in the next cycle.
REQ-034 SHALL cover x0 and no-rd cases: addi x0,x0,0 and sw x5,0(x2) issue back-to-back with no stall, and busy stays 0.
REQ-035 SHALL cover set/clear collision: wb_rd=7 retires in the same cycle another write to x7 issues -> busy[7] stays 1 and a dependent instruction stalls.
REQ-036 SHALL cover flush and reset: flush with 2 queued and ifu_valid=1 -> count=0 next cycle and the offered instruction is not accepted; rst_n low mid-transfer -> all outputs return to their reset values immediately.
